// File: rtl/spi_simple_pkg.sv
// Shared definitions for the spi_simple target: FSM encoding, default fill word
// and the bit-counter width helper.
package spi_simple_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  localparam logic [7:0] FILL_DEFAULT = 8'hFF;

  function automatic int bitcnt_w(input int data_w);
    return (data_w <= 2) ? 1 : $clog2(data_w);
  endfunction

endpackage

// File: rtl/spi_simple_sync.sv
// Multi-flop synchronizer for one SPI pin with one extra flop for rise/fall
// detection; events appear STAGES+1 clocks after the pin edge at the consumer.
module spi_simple_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic resetb,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int N = (STAGES < 2) ? 2 : STAGES;

  logic [N-1:0] sync_q;
  logic         prev_q;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sync_q <= {N{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[N-2:0], pin};
      prev_q <= sync_q[N-1];
    end
  end

  assign level = sync_q[N-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_simple_target.sv
// SPI mode-0 target: oversampled pins, MSB-first shifting, valid/ready rx and tx
// holding registers. Define SPI_SIMPLE_TARGET_STATS_EN to add word/error counters.
module spi_simple_target
  import spi_simple_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter logic [DATA_W-1:0] FILL        = DATA_W'(FILL_DEFAULT),
  parameter int                SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              resetb,
  input  logic              spi_sclk,
  input  logic              spi_csb,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_overrun,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_underrun,
  output logic              busy,
  output logic              frame_start,
  output logic              frame_end
`ifdef SPI_SIMPLE_TARGET_STATS_EN
  ,
  output logic [15:0]       stat_words,
  output logic [15:0]       stat_errors
`endif
);

  localparam int BCW = bitcnt_w(DATA_W);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);

  // Pin order: 0 = SCLK, 1 = CSB (idles high), 2 = MOSI
  logic [2:0] pin_raw, pin_lvl, pin_rise, pin_fall;
  assign pin_raw = {spi_mosi, spi_csb, spi_sclk};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      spi_simple_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL ((gi == 1) ? 1'b1 : 1'b0)
      ) u_sync (
        .clock  (clock),
        .resetb (resetb),
        .pin    (pin_raw[gi]),
        .level  (pin_lvl[gi]),
        .rise   (pin_rise[gi]),
        .fall   (pin_fall[gi])
      );
    end
  endgenerate

  logic sync_unused;
  assign sync_unused = ^{pin_lvl[0], pin_rise[2], pin_fall[2]};

  state_e              state_q, state_d;
  logic [BCW-1:0]      bitcnt_q, bitcnt_d;
  logic [DATA_W-2:0]   rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic [DATA_W-1:0]   tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0]   tx_hold_q, tx_hold_d;
  logic                tx_full_q, tx_full_d;
  logic                miso_q, miso_d;
  logic                fstart_q, fstart_d, fend_q, fend_d;
  logic                ovr_q, ovr_d, und_q, und_d;
  logic                load, complete;
  logic [DATA_W-1:0]   rx_word, load_word;

  assign rx_word = {rx_shift_q, pin_lvl[2]};

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    tx_shift_d = tx_shift_q;
    tx_hold_d  = tx_hold_q;
    tx_full_d  = tx_full_q;
    miso_d     = miso_q;
    fstart_d   = 1'b0;
    fend_d     = 1'b0;
    ovr_d      = 1'b0;
    und_d      = 1'b0;
    load       = 1'b0;
    complete   = 1'b0;
    load_word  = FILL;

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    // CSB events are checked first so they win over a coincident SCLK edge
    case (state_q)
      ST_IDLE: begin
        if (pin_fall[1]) begin
          state_d  = ST_ACTIVE;
          fstart_d = 1'b1;
          bitcnt_d = '0;
          load     = 1'b1;
        end
      end
      default: begin
        if (pin_rise[1]) begin
          state_d  = ST_IDLE;
          fend_d   = 1'b1;
          bitcnt_d = '0;
          miso_d   = 1'b0;
        end else if (pin_rise[0]) begin
          rx_shift_d = rx_word[DATA_W-2:0];
          bitcnt_d   = (bitcnt_q == LAST_BIT) ? '0 : bitcnt_q + 1'b1;
          complete   = (bitcnt_q == LAST_BIT);
        end else if (pin_fall[0]) begin
          if (bitcnt_q == '0) begin
            load = 1'b1;
          end else begin
            tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
            miso_d     = tx_shift_q[DATA_W-2];
          end
        end
      end
    endcase

    if (complete) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = rx_word;
        rx_valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end

    if (load) begin
      if (tx_full_q) begin
        load_word = tx_hold_q;
        tx_full_d = 1'b0;
      end else if (tx_valid) begin
        load_word = tx_data;
      end else begin
        und_d = 1'b1;
      end
      tx_shift_d = load_word;
      miso_d     = load_word[DATA_W-1];
    end else if (tx_valid && !tx_full_q) begin
      tx_hold_d = tx_data;
      tx_full_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q    <= ST_IDLE;
      bitcnt_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_shift_q <= '0;
      tx_hold_q  <= '0;
      tx_full_q  <= 1'b0;
      miso_q     <= 1'b0;
      fstart_q   <= 1'b0;
      fend_q     <= 1'b0;
      ovr_q      <= 1'b0;
      und_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_shift_q <= tx_shift_d;
      tx_hold_q  <= tx_hold_d;
      tx_full_q  <= tx_full_d;
      miso_q     <= miso_d;
      fstart_q   <= fstart_d;
      fend_q     <= fend_d;
      ovr_q      <= ovr_d;
      und_q      <= und_d;
    end
  end

`ifdef SPI_SIMPLE_TARGET_STATS_EN
  logic [15:0] words_q, errors_q;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      words_q  <= '0;
      errors_q <= '0;
    end else begin
      if (complete && words_q != 16'hFFFF) words_q <= words_q + 16'd1;
      // overrun and underrun come from opposite SCLK edges, never together
      if ((ovr_q || und_q) && errors_q != 16'hFFFF) errors_q <= errors_q + 16'd1;
    end
  end

  assign stat_words  = words_q;
  assign stat_errors = errors_q;
`endif

  assign spi_miso    = miso_q;
  assign spi_miso_oe = (state_q == ST_ACTIVE);
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_overrun  = ovr_q;
  assign tx_ready    = ~tx_full_q;
  assign tx_underrun = und_q;
  assign busy        = ~pin_lvl[1];
  assign frame_start = fstart_q;
  assign frame_end   = fend_q;

endmodule

// File: tb/tb_spi_simple_target.sv
// Scoreboard bench for spi_simple_target: a bit-banged initiator, a tx feeder
// and a negedge monitor that compares rx words and MISO words against queues.
module tb_spi_simple_target;

  logic       clock = 1'b0;
  logic       resetb = 1'b0;
  logic       spi_sclk = 1'b0, spi_csb = 1'b1, spi_mosi = 1'b0;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready = 1'b1, rx_overrun;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_underrun, busy, frame_start, frame_end;
`ifdef SPI_SIMPLE_TARGET_STATS_EN
  logic [15:0] stat_words, stat_errors;
`endif

  always #5 clock = ~clock;

  spi_simple_target dut (
    .clock(clock), .resetb(resetb),
    .spi_sclk(spi_sclk), .spi_csb(spi_csb), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_overrun(rx_overrun),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_underrun(tx_underrun),
    .busy(busy), .frame_start(frame_start), .frame_end(frame_end)
`ifdef SPI_SIMPLE_TARGET_STATS_EN
    , .stat_words(stat_words), .stat_errors(stat_errors)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Scoreboard queues: written only by the stimulus process, read by index
  logic [7:0] rx_exp[$];
  logic [7:0] miso_exp[$];
  logic [7:0] miso_obs[$];
  logic [7:0] tx_src[$];
  int rx_rd = 0, miso_rd = 0, tx_rd = 0;
  bit tx_hs = 0;

  int n_fs = 0, n_fe = 0, n_ovr = 0, n_und = 0, n_txfull = 0, n_rxv = 0;

  // tx feeder: the handshake seen at one negedge happens at the next posedge
  always @(negedge clock) begin
    if (tx_hs) tx_rd++;
    tx_valid = (tx_rd < tx_src.size());
    tx_data  = tx_valid ? tx_src[tx_rd] : 8'h00;
    tx_hs    = tx_valid && tx_ready;
  end

  always @(negedge clock) begin
    if (resetb) begin
      n_fs     += int'(frame_start);
      n_fe     += int'(frame_end);
      n_ovr    += int'(rx_overrun);
      n_und    += int'(tx_underrun);
      n_txfull += int'(!tx_ready);
      n_rxv    += int'(rx_valid);
    end
    if (rx_valid && rx_ready && resetb) begin
      checks++;
      if (rx_rd >= rx_exp.size()) begin
        failures++;
        $display("FAIL rx_unexpected got=%02h", rx_data);
      end else if (rx_data !== rx_exp[rx_rd]) begin
        failures++;
        $display("FAIL rx_word[%0d] got=%02h exp=%02h", rx_rd, rx_data, rx_exp[rx_rd]);
      end else begin
        $display("rx  word[%0d] = %02h", rx_rd, rx_data);
      end
      rx_rd++;
    end
    while (miso_rd < miso_obs.size()) begin
      checks++;
      if (miso_rd >= miso_exp.size()) begin
        failures++;
        $display("FAIL miso_unexpected got=%02h", miso_obs[miso_rd]);
      end else if (miso_obs[miso_rd] !== miso_exp[miso_rd]) begin
        failures++;
        $display("FAIL miso_word[%0d] got=%02h exp=%02h", miso_rd, miso_obs[miso_rd], miso_exp[miso_rd]);
      end else begin
        $display("miso word[%0d] = %02h", miso_rd, miso_obs[miso_rd]);
      end
      miso_rd++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end else begin
      $display("chk %s = %0h", name, act);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  logic [7:0] fw [0:3];

  // Mode-0 initiator; the final SCLK fall coincides with CSB rise.
  // abort_bits > 0 ends the frame after that many bits of word 0.
  task automatic spi_frame(input int nwords, input int abort_bits);
    logic [7:0] mi;
    int bits;
    bits = 0;
    spi_csb = 1'b0;
    cyc(6);
    for (int w = 0; w < nwords; w++) begin
      for (int b = 7; b >= 0; b--) begin
        spi_mosi = fw[w][b];
        cyc(5);
        spi_sclk = 1'b1;
        mi[b] = spi_miso;
        cyc(5);
        bits++;
        spi_sclk = 1'b0;
        if ((w == nwords - 1 && b == 0) || bits == abort_bits) begin
          spi_csb = 1'b1;
          break;
        end
      end
      if (abort_bits == 0) miso_obs.push_back(mi);
      else break;
    end
    cyc(12);
  endtask

  int s_fs, s_fe, s_ovr, s_und, s_txfull, s_rxv;
  task automatic snap();
    s_fs = n_fs; s_fe = n_fe; s_ovr = n_ovr; s_und = n_und;
    s_txfull = n_txfull; s_rxv = n_rxv;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_miso"}, int'(spi_miso), 0);
    check({tag, "_oe"}, int'(spi_miso_oe), 0);
    check({tag, "_rx_valid"}, int'(rx_valid), 0);
    check({tag, "_rx_data"}, int'(rx_data), 0);
    check({tag, "_tx_ready"}, int'(tx_ready), 1);
    check({tag, "_pulses"}, int'({frame_start, frame_end, rx_overrun, tx_underrun}), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    cyc(3);
    check_reset_values("reset0");
    resetb = 1'b1;
    cyc(4);

    // 1: preloaded reply 3C, MOSI A5
    tx_src.push_back(8'h3C);
    cyc(4);
    check("t1_tx_ready_full", int'(tx_ready), 0);
    snap();
    fw[0] = 8'hA5; rx_exp.push_back(8'hA5); miso_exp.push_back(8'h3C);
    spi_frame(1, 0);
    check("t1_frame_start", n_fs - s_fs, 1);
    check("t1_frame_end", n_fe - s_fe, 1);
    check("t1_underrun", n_und - s_und, 0);
    check("t1_tx_ready", int'(tx_ready), 1);

    // 2: three words, rx held off, replies streamed through the holding register
    rx_ready = 1'b0;
    tx_src.push_back(8'h44); tx_src.push_back(8'h55); tx_src.push_back(8'h66);
    cyc(4);
    snap();
    fw[0] = 8'h11; fw[1] = 8'h22; fw[2] = 8'h33;
    miso_exp.push_back(8'h44); miso_exp.push_back(8'h55); miso_exp.push_back(8'h66);
    rx_exp.push_back(8'h11);
    spi_frame(3, 0);
    check("t2_overrun", n_ovr - s_ovr, 2);
    check("t2_underrun", n_und - s_und, 0);
    check("t2_rx_valid_held", int'(rx_valid), 1);
    check("t2_rx_data_kept", int'(rx_data), 8'h11);
    rx_ready = 1'b1;
    cyc(3);

    // 3: no reply words -> fill bytes
    snap();
    fw[0] = 8'h96; fw[1] = 8'h69;
    rx_exp.push_back(8'h96); rx_exp.push_back(8'h69);
    miso_exp.push_back(8'hFF); miso_exp.push_back(8'hFF);
    spi_frame(2, 0);
    check("t3_underrun", n_und - s_und, 2);
    check("t3_tx_ready_stays", n_txfull - s_txfull, 0);
`ifdef SPI_SIMPLE_TARGET_STATS_EN
    check("stat_words", int'(stat_words), 6);
    check("stat_errors", int'(stat_errors), 4);
`endif

    // 4: abort after 5 bits, then a clean frame
    snap();
    fw[0] = 8'hFF;
    spi_frame(1, 5);
    check("t4_frame_end", n_fe - s_fe, 1);
    check("t4_no_rx_valid", n_rxv - s_rxv, 0);
    check("t4_oe_low", int'(spi_miso_oe), 0);
    fw[0] = 8'h5A; rx_exp.push_back(8'h5A); miso_exp.push_back(8'hFF);
    spi_frame(1, 0);

    // 5: reset mid-word, then a clean frame
    spi_csb = 1'b0;
    cyc(6);
    for (int b = 0; b < 3; b++) begin
      spi_mosi = b[0];
      cyc(5); spi_sclk = 1'b1; cyc(5); spi_sclk = 1'b0;
    end
    cyc(2);
    resetb = 1'b0;
    cyc(2);
    check_reset_values("reset_mid");
    spi_csb = 1'b1;
    cyc(4);
    check_reset_values("reset_hold");
    resetb = 1'b1;
    cyc(4);
    fw[0] = 8'hC3; rx_exp.push_back(8'hC3); miso_exp.push_back(8'hFF);
    spi_frame(1, 0);

    cyc(4);
    check("all_rx_consumed", rx_rd, rx_exp.size());
    check("all_miso_seen", miso_obs.size(), miso_exp.size());
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

endmodule
